// File: rtl/sseg_keypad_mux.sv
// Debounces one-hot keypad presses into a right-entering hex digit buffer and
// time-multiplexes the buffer onto a shared seven-segment bus with per-digit enables.
module sseg_keypad_mux #(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 1000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [15:0]                          keyin,
    input  logic                                 clr,
    output logic [7:0]                           sseg,
    output logic [NUM_DIGITS-1:0]                an,
    output logic                                 key_strobe,
    output logic [3:0]                           key_code,
    output logic [$clog2(NUM_DIGITS+1)-1:0]      digit_count
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NUM_DIGITS);
    localparam logic [7:0]    SEG_POL  = {8{~ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{ACTIVE_LOW}};

    // Hex value of keypad bit i lives in nibble i.
    localparam logic [63:0] KEY_HEX = {4'hF, 4'hE, 4'h0, 4'hD, 4'hC, 4'h9, 4'h8, 4'h7,
                                       4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             key_lat_q, key_lat_d;
    logic [DW-1:0]           deb_cnt_q, deb_cnt_d;
    logic [4:0]              entry_q [NUM_DIGITS];
    logic [4:0]              entry_d [NUM_DIGITS];
    logic [CW-1:0]           count_q, count_d;
    logic                    key_strobe_q, key_strobe_d;
    logic [3:0]              key_code_q, key_code_d;
    logic [RW-1:0]           ref_cnt_q, ref_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic                    key_valid;
    logic                    push;
    logic [3:0]              push_code;

    function automatic logic [3:0] key_to_hex(input logic [15:0] k);
        logic [3:0] h;
        h = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) h = KEY_HEX[i*4 +: 4];
        end
        return h;
    endfunction

    // Entry format is {valid, hex}; an invalid entry displays blank.
    function automatic logic [7:0] hex_to_seg(input logic [4:0] e);
        logic [7:0] s;
        s = 8'hFF;
        if (e[4]) begin
            case (e[3:0])
                4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
                4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
                4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
                4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
            endcase
        end
        return s;
    endfunction

    assign key_valid = (keyin != 16'h0) && ((keyin & (keyin - 16'h1)) == 16'h0);
    assign push_code = key_to_hex(key_lat_q);

    always_comb begin
        state_d   = state_q;
        key_lat_d = key_lat_q;
        deb_cnt_d = deb_cnt_q;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_lat_d = keyin;
                    deb_cnt_d = '0;
                    state_d   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (keyin != key_lat_q) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    push    = 1'b1;
                    state_d = HELD;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (keyin == 16'h0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_strobe_d = push;
        key_code_d   = push ? push_code : key_code_q;
        count_d      = count_q;
        for (int i = 0; i < NUM_DIGITS; i++) entry_d[i] = entry_q[i];
        // A clear on the push cycle drops the new digit; the strobe still fires.
        if (clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) entry_d[i] = '0;
            count_d = '0;
        end else if (push) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) entry_d[i] = entry_q[i-1];
            entry_d[0] = {1'b1, push_code};
            if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_cnt_q == REF_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) an_onehot[i] = (idx_q == IW'(i));
        an_d   = an_onehot ^ AN_POL;
        sseg_d = hex_to_seg(entry_q[idx_q]) ^ SEG_POL;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            key_lat_q    <= '0;
            deb_cnt_q    <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= '0;
            count_q      <= '0;
            key_strobe_q <= 1'b0;
            key_code_q   <= '0;
            ref_cnt_q    <= '0;
            idx_q        <= '0;
            sseg_q       <= 8'hFF ^ SEG_POL;
            an_q         <= NUM_DIGITS'(1) ^ AN_POL;
        end else begin
            state_q      <= state_d;
            key_lat_q    <= key_lat_d;
            deb_cnt_q    <= deb_cnt_d;
            for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= entry_d[i];
            count_q      <= count_d;
            key_strobe_q <= key_strobe_d;
            key_code_q   <= key_code_d;
            ref_cnt_q    <= ref_cnt_d;
            idx_q        <= idx_d;
            sseg_q       <= sseg_d;
            an_q         <= an_d;
        end
    end

    assign sseg        = sseg_q;
    assign an          = an_q;
    assign key_strobe  = key_strobe_q;
    assign key_code    = key_code_q;
    assign digit_count = count_q;
endmodule

// File: tb/tb_sseg_keypad_mux.sv
// Randomized and directed bench for sseg_keypad_mux against a press-level model:
// a press is accepted iff it is one-hot and held for DEBOUNCE_CYCLES+1 samples.
module tb_sseg_keypad_mux;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DC = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] keyin = 16'h0;
    logic [7:0]  sseg;
    logic [3:0]  an;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [2:0]  digit_count;

    sseg_keypad_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut (
        .CLK(CLK), .RST(RST), .keyin(keyin), .clr(clr), .sseg(sseg), .an(an),
        .key_strobe(key_strobe), .key_code(key_code), .digit_count(digit_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int model_buf[$];
    logic [3:0] model_code = 4'h0;
    logic [7:0] seg_tab [16];
    int key_tab [16];

    // Strobe is read before the edge updates it, so each pulse is counted once.
    always @(posedge CLK) if (key_strobe === 1'b1) strobes++;

    task automatic model_push(input int d);
        model_buf.push_front(d);
        if (model_buf.size() > ND) void'(model_buf.pop_back());
        model_code = 4'(d);
    endtask

    task automatic check_display(input string name);
        int zeros, idx;
        logic [7:0] exp_seg;
        repeat (ND * RD) begin
            @(negedge CLK);
            zeros = 0; idx = 0;
            for (int i = 0; i < ND; i++) if (an[i] === 1'b0) begin zeros++; idx = i; end
            checks++;
            if (zeros != 1) begin
                errors++;
                $display("FAIL %s an_onehot: got %b, need exactly one low bit", name, an);
            end else begin
                exp_seg = (idx < model_buf.size()) ? seg_tab[model_buf[idx]] : 8'hFF;
                checks++;
                if (sseg !== exp_seg) begin
                    errors++;
                    $display("FAIL %s sseg digit%0d: got %h, expected %h", name, idx, sseg, exp_seg);
                end
            end
        end
    endtask

    task automatic do_press(input string name, input logic [15:0] k, input int hold, input int rel);
        int s0, bitn;
        bit acc;
        s0 = strobes;
        keyin = k;
        repeat (hold) @(negedge CLK);
        keyin = 16'h0;
        repeat (rel) @(negedge CLK);
        acc = ($countones(k) == 1) && (hold >= DC + 1);
        if (acc) begin
            bitn = 0;
            for (int i = 0; i < 16; i++) if (k[i]) bitn = i;
            model_push(key_tab[bitn]);
        end
        checks++;
        if (strobes - s0 != (acc ? 1 : 0)) begin
            errors++;
            $display("FAIL %s strobes key=%h hold=%0d: got %0d, expected %0d", name, k, hold, strobes - s0, acc ? 1 : 0);
        end
        checks++;
        if (key_code !== model_code) begin
            errors++;
            $display("FAIL %s key_code: got %h, expected %h", name, key_code, model_code);
        end
        checks++;
        if (digit_count !== 3'(model_buf.size())) begin
            errors++;
            $display("FAIL %s digit_count: got %0d, expected %0d", name, digit_count, model_buf.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; keyin = 16'h0; clr = 1'b0;
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (sseg !== 8'hFF || an !== 4'b1110) begin
            errors++;
            $display("FAIL reset_display: got sseg=%h an=%b, expected FF 1110", sseg, an);
        end
        checks++;
        if (key_strobe !== 1'b0 || key_code !== 4'h0 || digit_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got strobe=%b code=%h count=%0d, expected 0 0 0", key_strobe, key_code, digit_count);
        end
        RST = 1'b0;
        model_buf.delete();
        model_code = 4'h0;
        @(negedge CLK);
    endtask

    task automatic test_single_key();
        do_press("single", 16'h0020, 5, 2);
        check_display("single");
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 5; i++) do_press("sequence", 16'h0001 << i, 5, 1);
        check_display("sequence");
    endtask

    task automatic test_bounce();
        int s0;
        s0 = strobes;
        keyin = 16'h0001;
        repeat (2) @(negedge CLK);
        keyin = 16'h0002;
        repeat (2) @(negedge CLK);
        checks++;
        if (strobes != s0) begin
            errors++;
            $display("FAIL bounce_reject: got %0d strobes, expected 0", strobes - s0);
        end
        repeat (3) @(negedge CLK);
        keyin = 16'h0;
        @(negedge CLK);
        model_push(2);
        checks++;
        if (strobes - s0 != 1 || key_code !== 4'h2) begin
            errors++;
            $display("FAIL bounce_accept: got strobes=%0d code=%h, expected 1 2", strobes - s0, key_code);
        end
    endtask

    task automatic test_multihot();
        do_press("multihot", 16'h0003, 10, 1);
        check_display("multihot");
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = strobes;
        keyin = 16'h0040;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (sseg !== 8'hFF || an !== 4'b1110 || digit_count !== 3'd0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: got sseg=%h an=%b count=%0d code=%h, expected FF 1110 0 0", sseg, an, digit_count, key_code);
        end
        RST = 1'b0;
        model_buf.delete();
        model_code = 4'h0;
        repeat (4) @(negedge CLK);
        keyin = 16'h0;
        @(negedge CLK);
        model_push(6);
        checks++;
        if (strobes - s0 != 1 || key_code !== 4'h6 || digit_count !== 3'd1) begin
            errors++;
            $display("FAIL reset_repress: got strobes=%0d code=%h count=%0d, expected 1 6 1", strobes - s0, key_code, digit_count);
        end
    endtask

    task automatic test_refresh();
        logic [3:0] exp_an [5];
        logic [3:0] prev, cur;
        int len;
        bit found;
        exp_an[0] = 4'b1101; exp_an[1] = 4'b1011; exp_an[2] = 4'b0111;
        exp_an[3] = 4'b1110; exp_an[4] = 4'b1101;
        found = 0;
        prev = an;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge CLK);
            if (an === 4'b1101 && prev !== 4'b1101) found = 1;
            prev = an;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL refresh_start: an never advanced to 1101, last %b", an);
        end else begin
            for (int r = 0; r < 5; r++) begin
                cur = an;
                checks++;
                if (cur !== exp_an[r]) begin
                    errors++;
                    $display("FAIL refresh_order run%0d: got %b, expected %b", r, cur, exp_an[r]);
                end
                len = 0;
                do begin
                    len++;
                    @(negedge CLK);
                end while (an === cur && len < 20);
                checks++;
                if (len != RD) begin
                    errors++;
                    $display("FAIL refresh_len run%0d: got %0d cycles, expected %0d", r, len, RD);
                end
            end
        end
    endtask

    task automatic test_clr_on_push();
        int s0;
        s0 = strobes;
        keyin = 16'h8000;
        repeat (3) @(negedge CLK);
        clr = 1'b1;
        @(negedge CLK);
        clr = 1'b0;
        keyin = 16'h0;
        @(negedge CLK);
        model_buf.delete();
        model_code = 4'hF;
        checks++;
        if (strobes - s0 != 1 || key_code !== 4'hF || digit_count !== 3'd0) begin
            errors++;
            $display("FAIL clr_push: got strobes=%0d code=%h count=%0d, expected 1 f 0", strobes - s0, key_code, digit_count);
        end
        check_display("clr_push");
    endtask

    task automatic test_random();
        logic [15:0] k;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) k = 16'h0001 << $urandom_range(0, 15);
            else k = 16'($urandom);
            do_press("random", k, int'($urandom_range(1, 6)), int'($urandom_range(1, 2)));
            if ($urandom_range(0, 9) == 0) begin
                clr = 1'b1;
                @(negedge CLK);
                clr = 1'b0;
                model_buf.delete();
                @(negedge CLK);
            end
        end
        check_display("random");
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        key_tab = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 13, 0, 14, 15};
        test_reset();
        test_single_key();
        test_sequence();
        test_bounce();
        test_multihot();
        test_reset_mid();
        test_refresh();
        test_clr_on_push();
        test_sequence();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
